register_file_32x64: RTL and testbench
======================================

REGISTER_FILE_32X64 -- requirements
Module: register_file_32x64

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each register and of the data ports.
REQ-002 Parameter REG_COUNT, default 32: number of architectural registers; the one-hot write bus is this wide.
REQ-003 Parameter SEL_WIDTH, default 5: width of the read-select ports (log2 of REG_COUNT).
REQ-004 Reset and clock: one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-low; 0 clears all state.
REQ-007 write_enable  input  1  write request qualifier.
REQ-008 write_onehot  input  REG_COUNT  one-hot destination from the upstream 5-to-32 decoder; bit k selects register k.
REQ-009 write_data  input  DATA_WIDTH  value to write.
REQ-010 read_req  input  1  read request; samples both read selects.
REQ-011 read_a_sel  input  SEL_WIDTH  register index for port A.
REQ-012 read_b_sel  input  SEL_WIDTH  register index for port B.
REQ-013 clear_error  input  1  synchronous clear of onehot_error.
REQ-014 read_a_data  output  DATA_WIDTH  registered port A data.
REQ-015 read_b_data  output  DATA_WIDTH  registered port B data.
REQ-016 read_valid  output  1  high for one cycle when read_a_data/read_b_data hold the response to a read_req.
REQ-017 onehot_error  output  1  sticky flag: an illegal write_onehot pattern was presented with write_enable=1.
REQ-018 write_count  output  16  count of committed writes, saturating.

Function
REQ-019 Storage SHALL be REG_COUNT registers of DATA_WIDTH bits; register REG_COUNT-1 (X31) SHALL be hard-wired zero: never written, always read as 0.
REQ-020 A write SHALL commit at the rising edge when write_enable=1 and write_onehot has exactly one bit set; the set bit position is the destination.
REQ-021 Write with write_onehot all-zero or with two or more bits set SHALL commit nothing and SHALL set onehot_error at that edge.
REQ-022 Legal write targeting X31 SHALL commit nothing, SHALL NOT set onehot_error, and SHALL NOT increment write_count.
REQ-023 write_enable=0 SHALL ignore write_onehot entirely (no write, no error), regardless of its value.
REQ-024 onehot_error SHALL stay 1 until clear_error=1 at an edge or reset; if clear_error and a new illegal write occur at the same edge, onehot_error SHALL be 1 after that edge (set wins).
REQ-025 write_count SHALL increment by 1 per committed write (REQ-020, excluding REQ-022) and SHALL hold at 16'hFFFF (no wrap).
REQ-026 Read latency SHALL be exactly 1 cycle: read_req=1 at edge N -> read_valid=1 and data valid after edge N, i.e. during cycle N+1; read_valid=0 after any edge with read_req=0.
REQ-027 read_a_data/read_b_data SHALL hold their last value when read_req=0.
REQ-028 Bypass: if a committed write at edge N targets the same index as a read sampled at edge N, that port SHALL return the new write_data, not the old contents.
REQ-029 Both ports reading the same register SHALL return identical data; any read of index 31 SHALL return 0, including under a simultaneous write attempt to X31.
REQ-030 Back-to-back read_req on consecutive cycles SHALL give read_valid high continuously, one response per request, in order.

Reset
REQ-031 While reset=0, all registers, read_a_data, read_b_data, read_valid, onehot_error and write_count SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight read response (read_valid=0) and any write presented in that cycle.
REQ-033 After reset deasserts, the first rising edge SHALL act normally (writes and reads accepted).

Verification
REQ-034 Write 64'hDEAD_BEEF_0000_0001 to X5 (onehot 32'h20), then read_req with A=5, B=31 -> next cycle read_a_data=64'hDEAD_BEEF_0000_0001, read_b_data=0, read_valid=1, write_count=1.
REQ-035 Same edge: write 64'h1234 to X7 and read_req A=7, B=7 -> both ports return 64'h1234 (bypass).
REQ-036 write_enable=1, write_onehot=32'h0000_0003 -> no register changes, onehot_error=1, write_count unchanged; clear_error pulse -> onehot_error=0.
REQ-037 Write 64'hFFFF to X31 (onehot 32'h8000_0000), then read A=31 -> read_a_data=0, onehot_error=0, write_count unchanged.
REQ-038 Preload write_count to 16'hFFFE via 2+ writes, continue writing -> count reaches 16'hFFFF and holds.
REQ-039 Read X5 pending, assert reset mid-cycle -> all outputs 0 immediately; after release, read X5 returns 0.

Source files
------------

// File: rtl/register_file_32x64.sv
// 32x64 register file with one-hot write port, two registered read ports,
// same-edge write-to-read bypass, hard-wired zero top register and write statistics.
module register_file_32x64 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned SEL_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [REG_COUNT-1:0]  write_onehot,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_req,
  input  logic [SEL_WIDTH-1:0]  read_a_sel,
  input  logic [SEL_WIDTH-1:0]  read_b_sel,
  input  logic                  clear_error,
  output logic [DATA_WIDTH-1:0] read_a_data,
  output logic [DATA_WIDTH-1:0] read_b_data,
  output logic                  read_valid,
  output logic                  onehot_error,
  output logic [15:0]           write_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [SEL_WIDTH-1:0] ZERO_IDX = SEL_WIDTH'(REG_COUNT - 1);

  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] read_a_data_q, read_a_data_d;
  logic [DATA_WIDTH-1:0] read_b_data_q, read_b_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  onehot_error_q, onehot_error_d;
  logic [CNT_W-1:0]      write_count_q, write_count_d;

  logic                  onehot_legal;
  logic [SEL_WIDTH-1:0]  wr_idx;
  logic                  wr_commit;

  // Decode the one-hot destination and decide whether this edge commits a write.
  always_comb begin
    onehot_legal = (write_onehot != '0) &&
                   ((write_onehot & (write_onehot - REG_COUNT'(1))) == '0);
    wr_idx = '0;
    for (int unsigned k = 0; k < REG_COUNT; k++) begin
      if (write_onehot[k]) wr_idx = wr_idx | SEL_WIDTH'(k);
    end
    wr_commit = write_enable && onehot_legal && (wr_idx != ZERO_IDX);
  end

  // Next-state for read ports, error flag and counter.
  always_comb begin
    read_a_data_d  = read_a_data_q;
    read_b_data_d  = read_b_data_q;
    read_valid_d   = read_req;
    onehot_error_d = onehot_error_q;
    write_count_d  = write_count_q;

    if (read_req) begin
      if (read_a_sel == ZERO_IDX)                  read_a_data_d = '0;
      else if (wr_commit && wr_idx == read_a_sel)  read_a_data_d = write_data;
      else                                         read_a_data_d = rf_q[read_a_sel];

      if (read_b_sel == ZERO_IDX)                  read_b_data_d = '0;
      else if (wr_commit && wr_idx == read_b_sel)  read_b_data_d = write_data;
      else                                         read_b_data_d = rf_q[read_b_sel];
    end

    // A new illegal write outranks a simultaneous clear.
    if (write_enable && !onehot_legal) onehot_error_d = 1'b1;
    else if (clear_error)              onehot_error_d = 1'b0;

    if (wr_commit && (write_count_q != '1)) write_count_d = write_count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < REG_COUNT; k++) rf_q[k] <= '0;
      read_a_data_q  <= '0;
      read_b_data_q  <= '0;
      read_valid_q   <= 1'b0;
      onehot_error_q <= 1'b0;
      write_count_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < REG_COUNT - 1; k++) begin
        if (wr_commit && write_onehot[k]) rf_q[k] <= write_data;
      end
      read_a_data_q  <= read_a_data_d;
      read_b_data_q  <= read_b_data_d;
      read_valid_q   <= read_valid_d;
      onehot_error_q <= onehot_error_d;
      write_count_q  <= write_count_d;
    end
  end

  assign read_a_data  = read_a_data_q;
  assign read_b_data  = read_b_data_q;
  assign read_valid   = read_valid_q;
  assign onehot_error = onehot_error_q;
  assign write_count  = write_count_q;

endmodule

// File: tb/tb_register_file_32x64.sv
// Directed vector bench for register_file_32x64: table of single-cycle
// transactions plus reset-mid-read and counter-saturation sequences.
module tb_register_file_32x64;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [31:0] write_onehot;
  logic [63:0] write_data;
  logic        read_req;
  logic [4:0]  read_a_sel;
  logic [4:0]  read_b_sel;
  logic        clear_error;
  logic [63:0] read_a_data;
  logic [63:0] read_b_data;
  logic        read_valid;
  logic        onehot_error;
  logic [15:0] write_count;

  int total = 0;
  int bad   = 0;

  register_file_32x64 dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .write_onehot (write_onehot),
    .write_data   (write_data),
    .read_req     (read_req),
    .read_a_sel   (read_a_sel),
    .read_b_sel   (read_b_sel),
    .clear_error  (clear_error),
    .read_a_data  (read_a_data),
    .read_b_data  (read_b_data),
    .read_valid   (read_valid),
    .onehot_error (onehot_error),
    .write_count  (write_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] oh;
    logic [63:0] wd;
    logic        rr;
    logic [4:0]  as;
    logic [4:0]  bs;
    logic        clr;
    logic [63:0] ea;
    logic [63:0] eb;
    logic        ev;
    logic        ee;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [63:0] ea, input logic [63:0] eb,
                         input logic ev, input logic ee, input logic [15:0] ec);
    chk({name, ".a"},   read_a_data, ea);
    chk({name, ".b"},   read_b_data, eb);
    chk({name, ".v"},   64'(read_valid), 64'(ev));
    chk({name, ".err"}, 64'(onehot_error), 64'(ee));
    chk({name, ".cnt"}, 64'(write_count), 64'(ec));
  endtask

  task automatic drive(input logic we, input logic [31:0] oh, input logic [63:0] wd,
                       input logic rr, input logic [4:0] as, input logic [4:0] bs,
                       input logic clr);
    write_enable = we; write_onehot = oh; write_data = wd;
    read_req = rr; read_a_sel = as; read_b_sel = bs; clear_error = clr;
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

  initial begin
    //                name          we  onehot          wdata            rr as  bs  clr  exp_a   exp_b    v  err cnt
    vecs[0]  = '{"wr_x5",        1, 32'h0000_0020, DB,             0, 0,  0,  0, 64'h0,  64'h0,   0, 0, 16'd1};
    vecs[1]  = '{"rd_x5_x31",    0, 32'h0,         64'h0,          1, 5,  31, 0, DB,     64'h0,   1, 0, 16'd1};
    vecs[2]  = '{"bypass_x7",    1, 32'h0000_0080, 64'h1234,       1, 7,  7,  0, 64'h1234, 64'h1234, 1, 0, 16'd2};
    vecs[3]  = '{"idle_hold",    0, 32'h0,         64'h0,          0, 0,  0,  0, 64'h1234, 64'h1234, 0, 0, 16'd2};
    vecs[4]  = '{"illegal_two",  1, 32'h0000_0003, 64'hAAAA,       0, 0,  0,  0, 64'h1234, 64'h1234, 0, 1, 16'd2};
    vecs[5]  = '{"rd_x0_x1",     0, 32'h0,         64'h0,          1, 0,  1,  0, 64'h0,  64'h0,   1, 1, 16'd2};
    vecs[6]  = '{"clear_err",    0, 32'h0,         64'h0,          0, 0,  0,  1, 64'h0,  64'h0,   0, 0, 16'd2};
    vecs[7]  = '{"wr_x31_rd",    1, 32'h8000_0000, 64'hFFFF,       1, 31, 5,  0, 64'h0,  DB,      1, 0, 16'd2};
    vecs[8]  = '{"rd_31_31",     0, 32'h0,         64'h0,          1, 31, 31, 0, 64'h0,  64'h0,   1, 0, 16'd2};
    vecs[9]  = '{"we0_ignore",   0, 32'h0000_0003, 64'h5555,       0, 0,  0,  0, 64'h0,  64'h0,   0, 0, 16'd2};
    vecs[10] = '{"zero_set_win", 1, 32'h0,         64'h7777,       0, 0,  0,  1, 64'h0,  64'h0,   0, 1, 16'd2};
    vecs[11] = '{"clear_err2",   0, 32'h0,         64'h0,          0, 0,  0,  1, 64'h0,  64'h0,   0, 0, 16'd2};
    vecs[12] = '{"bypass_x0",    1, 32'h0000_0001, 64'h11,         1, 0,  7,  0, 64'h11, 64'h1234, 1, 0, 16'd3};
    vecs[13] = '{"b2b_rd1",      0, 32'h0,         64'h0,          1, 7,  0,  0, 64'h1234, 64'h11, 1, 0, 16'd3};
    vecs[14] = '{"b2b_rd2",      0, 32'h0,         64'h0,          1, 5,  0,  0, DB,     64'h11,  1, 0, 16'd3};
    vecs[15] = '{"we0_x5",       0, 32'h0000_0020, 64'h9999,       1, 5,  5,  0, DB,     DB,      1, 0, 16'd3};

    drive(0, '0, '0, 0, '0, '0, 0);
    reset = 1'b0;
    #2;
    chk_all("reset", 64'h0, 64'h0, 0, 0, 16'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].oh, vecs[i].wd, vecs[i].rr, vecs[i].as, vecs[i].bs, vecs[i].clr);
      @(posedge clock); #1;
      chk_all(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].ev, vecs[i].ee, vecs[i].ec);
    end

    // Read X5 in flight, then reset mid-cycle with a write also presented.
    drive(0, '0, '0, 1, 5'd5, 5'd5, 0);
    @(posedge clock); #1;
    chk("pre_rst.v", 64'(read_valid), 64'h1);
    drive(1, 32'h0000_0020, 64'h4242, 1, 5'd5, 5'd5, 0);
    #2 reset = 1'b0;
    #1;
    chk_all("mid_rst", 64'h0, 64'h0, 0, 0, 16'd0);
    @(posedge clock); #1;
    chk_all("in_rst", 64'h0, 64'h0, 0, 0, 16'd0);
    reset = 1'b1;
    drive(0, '0, '0, 1, 5'd5, 5'd31, 0);
    @(posedge clock); #1;
    chk_all("post_rst_rd", 64'h0, 64'h0, 1, 0, 16'd0);

    // Saturate write_count.
    drive(1, 32'h0000_0002, 64'h1, 0, '0, '0, 0);
    repeat (65534) @(posedge clock);
    #1;
    chk("cnt_fffe", 64'(write_count), 64'hFFFE);
    @(posedge clock); #1;
    chk("cnt_ffff", 64'(write_count), 64'hFFFF);
    repeat (3) @(posedge clock);
    #1;
    chk("cnt_hold", 64'(write_count), 64'hFFFF);
    drive(0, '0, '0, 1, 5'd1, 5'd1, 0);
    @(posedge clock); #1;
    chk("sat_data", read_a_data, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
